// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_gen
//  Description : Multi-channel LED pattern driver. Each channel is OFF, ON,
//                BLINK (programmable half-period) or PWM (programmable duty).
//                A global sync input restarts every channel's counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
    parameter int              CHANNELS     = 4,
    parameter int              DIV_WIDTH    = 32,
    parameter int              PWM_WIDTH    = 8,
    parameter longint unsigned DEFAULT_HALF = 49_999_999,
    localparam int             CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [1:0]           cfg_mode,
    input  logic [DIV_WIDTH-1:0] cfg_half,
    input  logic [PWM_WIDTH-1:0] cfg_duty,
    input  logic                 sync,
    output logic [CHANNELS-1:0]  led,
    output logic [CHANNELS-1:0]  wrap
);

    localparam logic [1:0]           c_mode_off   = 2'd0;
    localparam logic [1:0]           c_mode_on    = 2'd1;
    localparam logic [1:0]           c_mode_blink = 2'd2;
    localparam logic [1:0]           c_mode_pwm   = 2'd3;
    localparam logic [DIV_WIDTH-1:0] c_default_half = DIV_WIDTH'(DEFAULT_HALF);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [1:0]           r_mode;
        logic [DIV_WIDTH-1:0] r_half;
        logic [PWM_WIDTH-1:0] r_duty;
        logic [DIV_WIDTH-1:0] r_cnt;
        logic [PWM_WIDTH-1:0] r_pwm_cnt;
        logic                 r_phase;
        logic                 r_event;
        logic                 r_led;
        logic                 r_wrap;
        logic                 w_sel;
        logic                 w_clr;
        logic                 w_blink_hit;
        logic                 w_pwm_hit;
        logic                 w_led_nxt;

        // Out-of-range channel numbers never match any generated index,
        // so such writes fall through with no effect.
        assign w_sel       = cfg_we && (cfg_ch == CH_W'(g));
        assign w_clr       = sync | w_sel;
        assign w_blink_hit = (r_cnt == r_half);
        assign w_pwm_hit   = &r_pwm_cnt;

        // LED level implied by the current (pre-edge) mode and counters
        always_comb begin
            w_led_nxt = 1'b0;
            case (r_mode)
                c_mode_off:   w_led_nxt = 1'b0;
                c_mode_on:    w_led_nxt = 1'b1;
                c_mode_blink: w_led_nxt = r_phase;
                c_mode_pwm:   w_led_nxt = (r_pwm_cnt < r_duty);
                default:      w_led_nxt = 1'b0;
            endcase
        end

        // Configuration registers, loaded only by a write to this channel
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mode <= c_mode_off;
                r_half <= c_default_half;
                r_duty <= '0;
            end else if (w_sel) begin
                r_mode <= cfg_mode;
                r_half <= cfg_half;
                r_duty <= cfg_duty;
            end
        end

        // Blink and PWM counters free-run in every mode; write or sync restarts them
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt     <= '0;
                r_pwm_cnt <= '0;
                r_phase   <= 1'b1;
            end else if (w_clr) begin
                r_cnt     <= '0;
                r_pwm_cnt <= '0;
                r_phase   <= 1'b1;
            end else begin
                r_pwm_cnt <= r_pwm_cnt + PWM_WIDTH'(1);
                if (w_blink_hit) begin
                    r_cnt   <= '0;
                    r_phase <= ~r_phase;
                end else begin
                    r_cnt   <= r_cnt + DIV_WIDTH'(1);
                end
            end
        end

        // Registered outputs; the wrap event is staged once so the pulse
        // lines up with the LED transition it marks.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_event <= 1'b0;
                r_led   <= 1'b0;
                r_wrap  <= 1'b0;
            end else begin
                r_event <= !w_clr &&
                           (((r_mode == c_mode_blink) && w_blink_hit) ||
                            ((r_mode == c_mode_pwm)   && w_pwm_hit));
                r_led   <= w_led_nxt;
                r_wrap  <= r_event;
            end
        end

        assign led[g]  = r_led;
        assign wrap[g] = r_wrap;
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_gen
//  Description : Self-checking bench for led_pattern_gen (4- and 3-channel
//                instances sharing stimulus) against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_half;
    logic [7:0]  cfg_duty;
    logic        sync;
    logic [3:0]  led;
    logic [3:0]  wrap;
    logic [2:0]  led3;
    logic [2:0]  wrap3;

    int pass_cnt  = 0;
    int total_cnt = 0;

    led_pattern_gen #(.CHANNELS(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_duty(cfg_duty),
        .sync(sync), .led(led), .wrap(wrap)
    );

    led_pattern_gen #(.CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_duty(cfg_duty),
        .sync(sync), .led(led3), .wrap(wrap3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // t = counting edges since the channel was last restarted
    int         m_mode [4];
    longint     m_half [4];
    int         m_duty [4];
    longint     m_t    [4];
    bit         m_pend [4];
    logic [3:0] m_led;
    logic [3:0] m_wrap;

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            m_mode[c] = 0;
            m_half[c] = 49_999_999;
            m_duty[c] = 0;
            m_t[c]    = 0;
            m_pend[c] = 1'b0;
        end
        m_led  = '0;
        m_wrap = '0;
    endfunction

    function automatic bit model_led(int c);
        case (m_mode[c])
            1:       return 1'b1;
            2:       return ((m_t[c] / (m_half[c] + 1)) % 2) == 0;
            3:       return (m_t[c] % 256) < m_duty[c];
            default: return 1'b0;
        endcase
    endfunction

    function automatic void model_edge();
        for (int c = 0; c < 4; c++) begin
            bit wr;
            bit clr;
            wr  = cfg_we && (int'(cfg_ch) == c);
            clr = sync || wr;
            m_led[c]  = model_led(c);
            m_wrap[c] = m_pend[c];
            m_pend[c] = !clr &&
                        ((m_mode[c] == 2 && (m_t[c] % (m_half[c] + 1)) == m_half[c]) ||
                         (m_mode[c] == 3 && (m_t[c] % 256) == 255));
            if (wr) begin
                m_mode[c] = int'(cfg_mode);
                m_half[c] = longint'(cfg_half);
                m_duty[c] = int'(cfg_duty);
            end
            m_t[c] = clr ? 0 : m_t[c] + 1;
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_led",   {28'd0, led},   {28'd0, m_led});
        check("model_wrap",  {28'd0, wrap},  {28'd0, m_wrap});
        check("model_led3",  {29'd0, led3},  {29'd0, m_led[2:0]});
        check("model_wrap3", {29'd0, wrap3}, {29'd0, m_wrap[2:0]});
    endtask

    task automatic idle();
        cfg_we = 1'b0; sync = 1'b0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] mode,
                      input logic [31:0] half, input logic [7:0] duty);
        cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_half = half; cfg_duty = duty;
    endtask

    typedef struct {
        logic       we;
        logic [1:0] ch;
        logic [1:0] mode;
        logic [31:0] half;
        logic       sy;
        logic [3:0] exp_led;
        logic [3:0] exp_wrap;
    } vec_t;

    vec_t tbl [11];

    int highs;
    int lows;
    int wraps;

    initial begin
        // Blink ch1 half=2: write at edge N, then rows show outputs at N+1..N+10
        tbl[0]  = '{1'b1, 2'd1, 2'd2, 32'd2, 1'b0, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 2'd0, 2'd0, 32'd0, 1'b0, 4'b0010, 4'b0000};
        tbl[2]  = '{1'b0, 2'd0, 2'd0, 32'd0, 1'b0, 4'b0010, 4'b0000};
        tbl[3]  = '{1'b0, 2'd0, 2'd0, 32'd0, 1'b0, 4'b0010, 4'b0000};
        tbl[4]  = '{1'b0, 2'd0, 2'd0, 32'd0, 1'b0, 4'b0000, 4'b0010};
        tbl[5]  = '{1'b0, 2'd0, 2'd0, 32'd0, 1'b0, 4'b0000, 4'b0000};
        tbl[6]  = '{1'b0, 2'd0, 2'd0, 32'd0, 1'b0, 4'b0000, 4'b0000};
        tbl[7]  = '{1'b0, 2'd0, 2'd0, 32'd0, 1'b0, 4'b0010, 4'b0010};
        tbl[8]  = '{1'b0, 2'd0, 2'd0, 32'd0, 1'b0, 4'b0010, 4'b0000};
        tbl[9]  = '{1'b1, 2'd1, 2'd0, 32'd0, 1'b0, 4'b0010, 4'b0000};
        tbl[10] = '{1'b0, 2'd0, 2'd0, 32'd0, 1'b0, 4'b0000, 4'b0000};

        rst_n = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_half = '0; cfg_duty = '0;
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_led",  {28'd0, led},  32'd0);
        check("reset_wrap", {28'd0, wrap}, 32'd0);

        // Idle after reset: everything stays dark
        repeat (100) tick();
        check("idle_led", {28'd0, led}, 32'd0);

        // Table-driven blink sequence
        for (int i = 0; i < 11; i++) begin
            cfg_we = tbl[i].we; cfg_ch = tbl[i].ch; cfg_mode = tbl[i].mode;
            cfg_half = tbl[i].half; cfg_duty = '0; sync = tbl[i].sy;
            tick();
            check($sformatf("tbl%0d_led", i),  {28'd0, led},  {28'd0, tbl[i].exp_led});
            check($sformatf("tbl%0d_wrap", i), {28'd0, wrap}, {28'd0, tbl[i].exp_wrap});
        end
        idle();

        // PWM duty=64: 128 high cycles and one wrap over two periods
        wr(2'd0, 2'd3, 32'd0, 8'd64); tick(); idle();
        highs = 0; wraps = 0;
        repeat (512) begin tick(); highs += int'(led[0]); wraps += int'(wrap[0]); end
        check("pwm64_high", highs, 128);
        check("pwm64_wrap", wraps, 1);

        // PWM duty=0: never high
        wr(2'd0, 2'd3, 32'd0, 8'd0); tick(); idle();
        highs = 0;
        repeat (256) begin tick(); highs += int'(led[0]); end
        check("pwm0_high", highs, 0);

        // PWM duty=255: exactly one low cycle per period
        wr(2'd0, 2'd3, 32'd0, 8'd255); tick(); idle();
        lows = 0;
        repeat (256) begin tick(); lows += int'(!led[0]); end
        check("pwm255_low", lows, 1);

        // Two blinkers written 3 cycles apart, then aligned by sync
        wr(2'd2, 2'd2, 32'd5, 8'd0); tick(); idle();
        tick(); tick();
        wr(2'd3, 2'd2, 32'd5, 8'd0); tick(); idle();
        repeat (4) tick();
        sync = 1'b1; tick(); sync = 1'b0;
        repeat (30) begin tick(); check("sync_align", {31'd0, led[2]}, {31'd0, led[3]}); end

        // Sync together with a write to ch2 gives the same alignment
        wr(2'd2, 2'd2, 32'd5, 8'd0); sync = 1'b1; tick(); idle();
        repeat (30) begin tick(); check("syncwr_align", {31'd0, wrap[2]}, {31'd0, wrap[3]}); end

        // Quiesce all channels
        for (int c = 0; c < 4; c++) begin wr(2'(c), 2'd0, 32'd0, 8'd0); tick(); end
        idle(); tick(); tick();

        // Out-of-range write on the 3-channel instance: no effect
        wr(2'd3, 2'd1, 32'd0, 8'd0); tick(); idle();
        repeat (5) begin tick(); check("oob_led3", {29'd0, led3}, 32'd0); end
        wr(2'd0, 2'd1, 32'd0, 8'd0); tick(); idle();
        tick();
        check("on_led3", {29'd0, led3}, 32'd1);

        // Reset mid-blink: outputs drop without waiting for a clock edge
        wr(2'd1, 2'd2, 32'd3, 8'd0); tick(); idle();
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led",  {28'd0, led},  32'd0);
        check("async_rst_led3", {29'd0, led3}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (20) tick();
        check("post_rst_led", {28'd0, led}, 32'd0);

        // Randomised traffic against the model
        repeat (3000) begin
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_ch   = 2'($urandom_range(0, 3));
            cfg_mode = 2'($urandom_range(0, 3));
            cfg_half = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0:       cfg_duty = 8'd0;
                1:       cfg_duty = 8'd255;
                default: cfg_duty = 8'($urandom_range(0, 255));
            endcase
            sync = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_pattern_gen.md
# led_pattern_gen

Multi-channel LED driver that generalises the single fixed-rate blinker into CHANNELS independent outputs. Each channel runs in one of four runtime-selectable modes: off, on, blink with programmable half-period, or PWM with programmable duty. The block sits between board LEDs and a simple register-write port driven by control logic. A global sync input phase-aligns all channels.

## Interface
- CHANNELS, 4, number of LED outputs (≥1)
- DIV_WIDTH, 32, width of blink half-period counter
- PWM_WIDTH, 8, width of PWM counter/duty
- DEFAULT_HALF, 49_999_999, reset value of every channel's half-period
- CH_W, derived = max(1, $clog2(CHANNELS)), channel-select width (localparam)

Ports:
- clk  in  1  system clock; single clock domain, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- cfg_we  in  1  config write strobe, one write per cycle
- cfg_ch  in  CH_W  target channel
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=PWM
- cfg_half  in  DIV_WIDTH  blink half-period minus one
- cfg_duty  in  PWM_WIDTH  PWM high count per PWM period
- sync  in  1  restart all channel counters
- led  out  CHANNELS  registered LED drive
- wrap  out  CHANNELS  one-cycle pulse per channel on blink toggle or PWM counter wrap

## Operation
- Per-channel state: mode, half, duty, cnt (DIV_WIDTH), pwm_cnt (PWM_WIDTH), phase (1 bit).
- Reset (rst_n low, async): mode=OFF, half=DEFAULT_HALF, duty=0, cnt=0, pwm_cnt=0, phase=1, led=0, wrap=0.
- Write: on an edge with cfg_we=1 and cfg_ch<CHANNELS, the addressed channel loads mode/half/duty and clears cnt=0, pwm_cnt=0, phase=1. Writes with cfg_ch≥CHANNELS are ignored without side effects. Other channels are unaffected.
- sync=1: every channel clears cnt, pwm_cnt and sets phase=1. Config registers are retained. Simultaneous sync and write: the write channel loads the new config and all channels are cleared. The result is identical to the write followed by sync.
- Counters run every cycle in all modes unless cleared (mode only gates led):
  - Blink: if cnt==half, then cnt<=0, phase<=~phase, wrap pulse. Otherwise cnt<=cnt+1.
  - PWM: pwm_cnt<=pwm_cnt+1, wrapping modulo 2^PWM_WIDTH. wrap pulses when pwm_cnt==all-ones, only when mode=PWM.
  - Blink wrap pulses only when mode=BLINK.
- led next value per mode, from pre-edge state: OFF→0; ON→1; BLINK→phase; PWM→(pwm_cnt < duty), unsigned compare.
- Boundaries:
  - half=0 toggles phase every cycle.
  - duty=0 keeps led at constant 0.
  - duty=2^PWM_WIDTH−1 gives 1 low cycle per 2^PWM_WIDTH.
  - Writing the same config again restarts the phase.

## Timing
- All outputs are registered. led and wrap reflect the state before the edge, so they carry one cycle of latency.
- Write sampled at edge N: led shows the new mode from edge N+1.
- Blink period is 2·(half+1) cycles, 50% duty. The first high interval after a write or sync is half+1 cycles, starting at N+1.
- PWM period is 2^PWM_WIDTH cycles. The high interval is duty cycles, starting at N+1.
- wrap asserts on the edge after the triggering counter condition, for exactly one cycle.
- Reset assertion mid-operation forces all outputs to 0 immediately. Deassertion is synchronised externally, and the first counting edge follows it.

## Test plan
- Reset then idle 100 cycles → led=0, wrap=0 on all channels; mode stays OFF.
- Write ch1 BLINK half=2 at edge N → led[1]=1 at N+1..N+3, 0 at N+4..N+6, 1 at N+7; wrap[1] at N+4 and N+7; other channels stay 0.
- Write ch0 PWM duty=64 (PWM_WIDTH=8) → led[0] high 64 cycles then low 192, repeating; wrap[0] once per 256 cycles. Check duty=0 (always 0) and duty=255 (1 low cycle per 256).
- Ch2 BLINK half=5 and ch3 BLINK half=5 written 3 cycles apart, then sync → both led toggle on identical edges thereafter; sync in the same cycle as a write to ch2 gives an identical result.
- Write with cfg_ch=CHANNELS (CHANNELS=3, CH_W=2, ch=3) → no output or state change on any channel; ch0 ON → led[0]=1 next cycle.
- rst_n low mid-blink for 2 cycles → led=0 asynchronously; after release all channels are OFF with half=DEFAULT_HALF.
